// File: rtl/legv8_imm_pkg.sv
// Shared types and opcode match constants for the LEGv8 immediate stage.
// Optional feature macro: LEGV8_IMM_BRANCH_SCALE_EN (see legv8_imm_decode).
package legv8_imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_B    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_D    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5,
        FMT_RSH  = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [6:0]  OP_ADDI  = 7'b1000100;
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;

endpackage

// File: rtl/legv8_imm_decode.sv
// Combinational LEGv8 format classifier and immediate extender.
// LEGV8_IMM_BRANCH_SCALE_EN turns B/CB word offsets into byte offsets.
module legv8_imm_decode
    import legv8_imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
);

    logic is_b, is_cb, is_d, is_i, is_iw, is_rsh;

    assign is_b   = (instr[31:26] == OP_B)
                 || (instr[31:26] == OP_BL);
    assign is_cb  = (instr[31:24] == OP_CBZ)
                 || (instr[31:24] == OP_CBNZ)
                 || (instr[31:24] == OP_BCOND);
    assign is_d   = (instr[31:21] == OP_LDUR)
                 || (instr[31:21] == OP_STUR);
    assign is_i   = instr[31]
                 && (instr[28:22] == OP_ADDI);
    assign is_iw  = (instr[31:23] == OP_MOVZ)
                 || (instr[31:23] == OP_MOVK);
    assign is_rsh = (instr[31:21] == OP_LSL)
                 || (instr[31:21] == OP_LSR);

    logic [XLEN-1:0] b_imm, cb_imm, d_imm;
    logic [XLEN-1:0] i_imm, iw_imm, rsh_imm;
    logic [63:0]     iw_wide;

`ifdef LEGV8_IMM_BRANCH_SCALE_EN
    assign b_imm  = {{(XLEN-28){instr[25]}},
                     instr[25:0], 2'b00};
    assign cb_imm = {{(XLEN-21){instr[23]}},
                     instr[23:5], 2'b00};
`else
    assign b_imm  = {{(XLEN-26){instr[25]}},
                     instr[25:0]};
    assign cb_imm = {{(XLEN-19){instr[23]}},
                     instr[23:5]};
`endif

    assign d_imm   = {{(XLEN-9){instr[20]}},
                      instr[20:12]};
    assign i_imm   = {{(XLEN-12){1'b0}},
                      instr[21:10]};
    assign rsh_imm = {{(XLEN-6){1'b0}},
                      instr[15:10]};

    // Shift in 64 bits, then keep the low XLEN bits.
    assign iw_wide = {48'd0, instr[20:5]}
                  << {instr[22:21], 4'd0};
    assign iw_imm  = iw_wide[XLEN-1:0];

    always_comb begin
        imm = '0;
        fmt = FMT_NONE;
        unique case (1'b1)
            is_b: begin
                imm = b_imm;
                fmt = FMT_B;
            end
            is_cb: begin
                imm = cb_imm;
                fmt = FMT_CB;
            end
            is_d: begin
                imm = d_imm;
                fmt = FMT_D;
            end
            is_i: begin
                imm = i_imm;
                fmt = FMT_I;
            end
            is_iw: begin
                imm = iw_imm;
                fmt = FMT_IW;
            end
            is_rsh: begin
                imm = rsh_imm;
                fmt = FMT_RSH;
            end
            default: begin
                imm = '0;
                fmt = FMT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/legv8_imm_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer.
// Optional feature macro: LEGV8_IMM_BRANCH_SCALE_EN (in legv8_imm_decode).
module legv8_imm_stage
    import legv8_imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;

    legv8_imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    state_e state, state_nxt;

    logic accept, drain;
    logic load_main, load_skid, skid_to_main;

    assign accept = in_valid && (state != ST_TWO);
    assign drain  = out_ready && (state != ST_EMPTY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) state_nxt = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && !drain)
                        state_nxt = ST_TWO;
                    else if (!accept && drain)
                        state_nxt = ST_EMPTY;
                end
                ST_TWO: begin
                    if (drain) state_nxt = ST_ONE;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (!flush) begin
            unique case (state)
                ST_EMPTY: load_main = accept;
                ST_ONE: begin
                    load_main = accept && drain;
                    load_skid = accept && !drain;
                end
                ST_TWO: skid_to_main = drain;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);

    logic [XLEN-1:0]  main_imm, skid_imm;
    logic [2:0]       main_fmt, skid_fmt;
    logic [TAG_W-1:0] main_tag, skid_tag;

    // Payload only moves on a load; otherwise it holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_imm <= '0;
            main_fmt <= FMT_NONE;
            main_tag <= '0;
            skid_imm <= '0;
            skid_fmt <= FMT_NONE;
            skid_tag <= '0;
        end else begin
            if (load_main) begin
                main_imm <= dec_imm;
                main_fmt <= dec_fmt;
                main_tag <= in_tag;
            end else if (skid_to_main) begin
                main_imm <= skid_imm;
                main_fmt <= skid_fmt;
                main_tag <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
                skid_tag <= in_tag;
            end
        end
    end

    assign out_imm = main_imm;
    assign out_fmt = main_fmt;
    assign out_tag = main_tag;

endmodule
